// File: rtl/mem_responder.sv
// Word-organised data RAM answering the CPU load/store port.
// Programmable wait states, valid/ready handshake, alignment/range errors.
module mem_responder #(
  parameter int          ADDR_W_WORDS = 10,
  parameter int          LATENCY      = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_W_WORDS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  generate
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be in 0..15");
    end
  endgenerate

  logic [1:0]              state;
  logic [3:0]              cnt;
  logic [31:0]             data;
  logic                    err;
  logic [31:0]             off;
  logic [ADDR_W_WORDS-1:0] widx;
  logic                    bad;
  logic                    accept;

  logic [31:0] mem [DEPTH];

  assign off  = req_addr - BASE_ADDR;
  assign widx = off[ADDR_W_WORDS+1:2];

  // The low-bound test guards the subtraction, so off never wraps when used.
  assign bad = (req_addr[1:0] != 2'b00)
            || (req_addr < BASE_ADDR)
            || ((off >> (ADDR_W_WORDS + 2)) != 32'd0);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  always_ff @(posedge clock) begin
    if (accept && req_write && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[widx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // The counter is loaded with LATENCY so RESP is entered LATENCY+1 edges after accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      data       <= 32'd0;
      err        <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= WAIT;
            cnt   <= 4'(LATENCY);
            err   <= bad;
            data  <= (bad || req_write) ? 32'd0 : mem[widx];
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_rdata <= data;
            resp_err   <= err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
